// File: rtl/divider_32bit_pkg.sv
// Shared constants, FSM state encoding and sign helper for divider_32bit.
package divider_32bit_pkg;

  localparam int XLEN       = 32;
  localparam int ITER_COUNT = 32;
  localparam logic [XLEN-1:0] DIV_ZERO_QUOTIENT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Two's-complement negate when n is set, pass-through otherwise.
  function automatic logic [XLEN-1:0] cond_neg(input logic n, input logic [XLEN-1:0] v);
    return n ? ({XLEN{1'b0}} - v) : v;
  endfunction

endpackage

// File: rtl/divider_32bit_div_step.sv
// One restoring-division step: trial-subtract the divisor magnitude from the
// shifted partial remainder; carry-out of the two's-complement add is not-borrow.
module div_step #(
  parameter int W = 32
) (
  input  logic [W:0]   i_rem_shift,
  input  logic [W-1:0] i_dmag,
  output logic [W-1:0] o_rem_next,
  output logic         o_q_bit
);

  logic [W+1:0] w_sum;
  logic         w_unused_hi;

  // rem_shift + ~{0,dmag} + 1, computed one bit wider to expose the carry.
  assign w_sum       = {1'b0, i_rem_shift} + {2'b01, ~i_dmag} + {{(W+1){1'b0}}, 1'b1};
  assign o_q_bit     = w_sum[W+1];
  // When the trial succeeds the difference is below dmag, so bit W is always 0.
  assign w_unused_hi = w_sum[W];
  assign o_rem_next  = o_q_bit ? w_sum[W-1:0] : i_rem_shift[W-1:0];

endmodule

// File: rtl/divider_32bit.sv
// Iterative 32-bit restoring divider: 32 RUN steps, one FIX cycle for signs,
// one DONE cycle. Zero divisor short-circuits IDLE->DONE.
// Optional macro DIVIDER_SIGNED_EN enables signed (DIV/REM) operation via is_signed.
module divider_32bit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            is_signed,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            div_by_zero
);
  import divider_32bit_pkg::*;

  state_e          r_state, w_next;
  logic [5:0]      r_cnt;
  logic [XLEN-1:0] r_rem, r_quo, r_dmag;
  logic [XLEN-1:0] r_quotient, r_remainder;
  logic            r_neg_q, r_neg_r, r_dz;
  logic            w_sgn, w_a_neg, w_b_neg, w_zero;
  logic [XLEN-1:0] w_rem_next;
  logic            w_qbit;

`ifdef DIVIDER_SIGNED_EN
  assign w_sgn = is_signed;
`else
  // Unsigned-only build: is_signed is deliberately ignored.
  logic w_unused_sgn;
  assign w_unused_sgn = is_signed;
  assign w_sgn        = 1'b0;
`endif

  assign w_a_neg = w_sgn & dividend[XLEN-1];
  assign w_b_neg = w_sgn & divisor[XLEN-1];
  assign w_zero  = (divisor == '0);

  div_step #(.W(XLEN)) u_step (
    .i_rem_shift ({r_rem, r_quo[XLEN-1]}),
    .i_dmag      (r_dmag),
    .o_rem_next  (w_rem_next),
    .o_q_bit     (w_qbit)
  );

  // State register; reset wins over any start in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = w_zero ? S_DONE : S_RUN;
      S_RUN:  if (r_cnt == 6'(ITER_COUNT - 1)) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Status outputs decoded from state.
  always_comb begin
    busy = (r_state != S_IDLE);
    done = (r_state == S_DONE);
  end

  // Datapath: operand capture, iteration, sign fix-up and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dmag      <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_dz        <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_dz  <= w_zero;
          r_cnt <= '0;
          if (w_zero) begin
            r_quotient  <= DIV_ZERO_QUOTIENT;
            r_remainder <= dividend;
          end else begin
            r_rem   <= '0;
            r_quo   <= cond_neg(w_a_neg, dividend);
            r_dmag  <= cond_neg(w_b_neg, divisor);
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
          end
        end
        S_RUN: begin
          r_rem <= w_rem_next;
          r_quo <= {r_quo[XLEN-2:0], w_qbit};
          r_cnt <= r_cnt + 6'd1;
        end
        S_FIX: begin
          r_quotient  <= cond_neg(r_neg_q, r_quo);
          r_remainder <= cond_neg(r_neg_r, r_rem);
        end
        default: ;
      endcase
    end
  end

  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dz;

endmodule
